im_loader: RTL and testbench
============================

# im_loader

Boot-time program loader that fills the CPU's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles 15-bit instruction words (7-bit opcode, 8-bit K). Each word is written to consecutive instruction-memory addresses starting at 0. The loader holds the CPU core until a complete frame with a valid checksum has been written.

## Interface
Parameters:
- TIMEOUT, 1024: idle cycles allowed between accepted bytes inside a frame before aborting; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte on in_data is offered.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle; transfer occurs when in_valid && in_ready at a rising edge.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  8  write address.
- im_data  out  15  {opcode[6:0], K[7:0]}.
- cpu_hold  out  1  high keeps the CPU (PC and register loads) frozen.
- done  out  1  frame loaded and checksum matched.
- err  out  1  frame rejected: bad header, bad checksum or timeout.

## Operation
Frame format: 0xA5 sync, N (word count, 0 means 256), then N pairs {HI, LO}, then CHK.
- HI: bit 7 must be 0; bits 6:0 are the opcode.
- LO: K.
- CHK: XOR of all 2N HI/LO bytes.

States:
- IDLE: in_ready=1. Accepting 0xA5 goes to COUNT. Any other byte is discarded.
- COUNT: accepting a byte sets remaining = byte (0 gives 256), addr = 0, chk = 0, then goes to HI.
- HI: accepting a byte with bit7=1 goes to ERROR. Otherwise latch the opcode, chk ^= byte, and go to LO.
- LO: accepting a byte latches K, chk ^= byte, and goes to WRITE.
- WRITE: in_ready=0, im_we=1 with the current im_addr/im_data. Then addr+1 and remaining-1. If remaining becomes 0, go to CHECK; otherwise go to HI.
- CHECK: accepting a byte equal to chk goes to DONE; any other value goes to ERROR.
- DONE: done=1, cpu_hold=0, in_ready=1. Accepting 0xA5 goes to COUNT, clears done and reasserts cpu_hold. Other bytes are discarded.
- ERROR: err=1, cpu_hold=1, in_ready=1. Accepting 0xA5 goes to COUNT and clears err. Other bytes are discarded.

Rules:
- in_ready is a Moore output of state: 1 in every state except WRITE.
- im_addr is 8 bits. With N=0 (256 words) it wraps 0xFF→0x00 after the final write. No address beyond 0xFF is ever produced.
- Words already written before an ERROR stay in memory. cpu_hold stays high, so the CPU never executes a partial program.
- Timeout: an idle counter runs in COUNT/HI/LO/CHECK. It clears on every accepted byte and on every state entry. When it reaches TIMEOUT, the next state is ERROR. The counter is inactive in IDLE/WRITE/DONE/ERROR.
- in_data is ignored whenever in_valid=0 or in_ready=0.

## Timing
- Reset (rst_n low, asynchronous) puts the block in IDLE with in_ready=1, im_we=0, im_addr=0x00, im_data=0, cpu_hold=1, done=0, err=0, chk=0 and the idle counter at 0.
- Reset asserted mid-frame aborts immediately. No im_we is issued while rst_n is low. After release the block is back in IDLE.
- Per word: the HI accept edge, then the LO accept edge, then im_we is high for exactly the cycle after the LO edge. im_addr and im_data are stable throughout that cycle.
- Minimum 3 cycles per word at a continuous in_valid.
- done or err is asserted the cycle after the CHK accept edge.
- cpu_hold falls in the same cycle that done rises.
- Best-case frame: 2 + 3N + 1 cycles from the sync accept to done.
- Timeout: err rises TIMEOUT+1 cycles after the last accepted byte, or after state entry.

## Test plan
- Load: A5, 02, 11, 22, 05, 33, CHK=0x05 → im_we at addr 0 with data 0x1122, then addr 1 with 0x0533. done=1 and cpu_hold=0 one cycle after CHK.
- Bad checksum: the same frame with CHK=0x06 → both writes occur, err=1, cpu_hold stays 1, done=0.
- Bad header: A5, 01, 0x80 → err=1 the cycle after the 0x80 is accepted. No im_we pulse.
- N=0: A5, 00, 256 pairs with valid CHK → 256 writes to addresses 0x00..0xFF in order, then done=1.
- Backpressure and timeout: in_valid held high through WRITE must not drop a byte. With TIMEOUT=8, stalling 9 cycles after the first HI → err=1. Sending A5 afterwards restarts the load and a valid frame then sets done.
- Reset mid-frame: pull rst_n low during LO → outputs return to reset values immediately and no write occurs. Garbage bytes sent after release are ignored until A5.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: boot-time program loader for the CPU instruction memory.
// Accepts a framed byte stream over valid/ready:
//   0xA5, N (0 => 256), N x {HI, LO}, CHK
// assembles 15-bit words {HI[6:0], LO}, and writes them to consecutive
// addresses starting at 0. cpu_hold stays high until a complete frame with
// a matching XOR checksum has been written.
module im_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [14:0] im_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    // Idle counter must be able to hold the value TIMEOUT itself.
    localparam int IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;

    // Running checksum update: XOR of every HI/LO byte in the frame.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc,
                                            input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which the inter-byte idle counter runs.
    function automatic logic is_timed(input state_t s);
        return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CHECK);
    endfunction

    state_t              state_q, state_d, next_s;
    logic [7:0]          addr_q, addr_d;
    logic [8:0]          remaining_q, remaining_d;
    logic [7:0]          chk_q, chk_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [14:0]         im_data_q, im_data_d;
    logic                im_we_q, im_we_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept_s;
    logic                timeout_s;
    logic                is_sync_s;

    assign accept_s  = in_valid && in_ready_q;
    assign is_sync_s = (in_data == SYNC_BYTE);
    // Timeout fires only when no byte arrives in the cycle the limit is hit.
    assign timeout_s = (TIMEOUT != 0) && is_timed(state_q) &&
                       (idle_q == IDLE_LIM) && !accept_s;

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = addr_q;
    assign im_data  = im_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        next_s      = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        chk_d       = chk_q;
        opcode_d    = opcode_q;
        im_data_d   = im_data_q;
        idle_d      = idle_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s && is_sync_s) begin
                    next_s = S_COUNT;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_COUNT: begin
                if (accept_s) begin
                    remaining_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    addr_d      = 8'h00;
                    chk_d       = 8'h00;
                    next_s      = S_HI;
                end else begin
                    next_s = S_COUNT;
                end
            end
            S_HI: begin
                if (accept_s) begin
                    if (in_data[7]) begin
                        next_s = S_ERROR;
                    end else begin
                        opcode_d = in_data[6:0];
                        chk_d    = chk_fold(chk_q, in_data);
                        next_s   = S_LO;
                    end
                end else begin
                    next_s = S_HI;
                end
            end
            S_LO: begin
                if (accept_s) begin
                    im_data_d = {opcode_q, in_data};
                    chk_d     = chk_fold(chk_q, in_data);
                    next_s    = S_WRITE;
                end else begin
                    next_s = S_LO;
                end
            end
            S_WRITE: begin
                // Address wraps 0xFF -> 0x00 after the 256th word.
                addr_d      = addr_q + 8'd1;
                remaining_d = remaining_q - 9'd1;
                if (remaining_q == 9'd1) begin
                    next_s = S_CHECK;
                end else begin
                    next_s = S_HI;
                end
            end
            S_CHECK: begin
                if (accept_s) begin
                    if (in_data == chk_q) begin
                        next_s = S_DONE;
                    end else begin
                        next_s = S_ERROR;
                    end
                end else begin
                    next_s = S_CHECK;
                end
            end
            S_DONE: begin
                if (accept_s && is_sync_s) begin
                    next_s = S_COUNT;
                end else begin
                    next_s = S_DONE;
                end
            end
            S_ERROR: begin
                if (accept_s && is_sync_s) begin
                    next_s = S_COUNT;
                end else begin
                    next_s = S_ERROR;
                end
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase

        if (timeout_s) begin
            state_d = S_ERROR;
        end else begin
            state_d = next_s;
        end

        // Idle counter clears on accepts and state entries; saturates at limit.
        if (!is_timed(state_d) || (state_d != state_q) || accept_s) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LIM) begin
            idle_d = idle_q + IDLE_ONE;
        end else begin
            idle_d = idle_q;
        end

        // Moore outputs registered from the next state.
        in_ready_d = (state_d != S_WRITE);
        im_we_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
        cpu_hold_d = (state_d != S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 8'h00;
            remaining_q <= 9'd0;
            chk_q       <= 8'h00;
            opcode_q    <= 7'd0;
            idle_q      <= '0;
            im_data_q   <= 15'd0;
            im_we_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            chk_q       <= chk_d;
            opcode_q    <= opcode_d;
            idle_q      <= idle_d;
            im_data_q   <= im_data_d;
            im_we_q     <= im_we_d;
            in_ready_q  <= in_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [14:0] im_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  frame_q[$];
    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    int          exp_outcome;   // 1 = done, 2 = err

    im_loader #(.TIMEOUT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Record every write-strobe cycle as {addr, data}.
    always @(negedge clk) begin
        if (im_we) got_q.push_back({im_addr, im_data});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check_val("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference: interpret frame_q per the frame rules -> exp_q, exp_outcome.
    task automatic model_frame();
        int n;
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        exp_q.delete();
        x = 8'h00;
        n = (frame_q[1] == 8'h00) ? 256 : int'(frame_q[1]);
        for (int i = 0; i < n; i++) begin
            hi = frame_q[2 + 2 * i];
            if (hi[7]) begin
                exp_outcome = 2;
                return;
            end
            lo = frame_q[3 + 2 * i];
            exp_q.push_back({i[7:0], hi[6:0], lo});
            x = x ^ hi ^ lo;
        end
        exp_outcome = (frame_q[2 + 2 * n] == x) ? 1 : 2;
    endtask

    task automatic run_frame(input string name, input int max_gap);
        model_frame();
        got_q.delete();
        foreach (frame_q[k]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(frame_q[k]);
        end
        check_val({name, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val({name, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
        check_val({name, "_done"}, 32'(done), 32'(exp_outcome == 1));
        check_val({name, "_err"}, 32'(err), 32'(exp_outcome == 2));
        check_val({name, "_hold"}, 32'(cpu_hold), 32'(exp_outcome != 1));
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_rdy"},  32'(in_ready), 32'd1);
        check_val({name, "_we"},   32'(im_we),    32'd0);
        check_val({name, "_addr"}, 32'(im_addr),  32'd0);
        check_val({name, "_data"}, 32'(im_data),  32'd0);
        check_val({name, "_hold"}, 32'(cpu_hold), 32'd1);
        check_val({name, "_done"}, 32'(done),     32'd0);
        check_val({name, "_err"},  32'(err),      32'd0);
    endtask

    // Build a random well-formed frame body; mode 1 corrupts CHK, mode 2 a header.
    task automatic build_frame(input int n, input int mode);
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        int bad_idx;
        bad_idx = $urandom_range(0, n - 1);
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            hi = 8'($urandom_range(0, 127));
            if (mode == 2 && i == bad_idx) begin
                hi = hi | 8'h80;
                frame_q.push_back(hi);
                return;
            end
            lo = 8'($urandom_range(0, 255));
            frame_q.push_back(hi);
            frame_q.push_back(lo);
            x = x ^ hi ^ lo;
        end
        if (mode == 1) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g;

        // Reset state
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed load, continuous valid (backpressure through WRITE)
        frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h05, 8'h33, 8'h05};
        run_frame("load", 0);
        check_val("load_w0", 32'(got_q.size() > 0 ? got_q[0] : 23'h0), 32'({8'h00, 15'h1122}));
        check_val("load_w1", 32'(got_q.size() > 1 ? got_q[1] : 23'h0), 32'({8'h01, 15'h0533}));

        // Bad checksum
        frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h05, 8'h33, 8'h06};
        run_frame("badchk", 0);

        // Bad header
        frame_q = '{8'hA5, 8'h01, 8'h80};
        run_frame("badhdr", 0);

        // N = 0 -> 256 words, address wraps back to 0
        build_frame(256, 0);
        frame_q[1] = 8'h00;
        run_frame("n256", 0);
        check_val("n256_wrap", 32'(im_addr), 32'd0);

        // Timeout: stall after first HI
        got_q.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (8) @(posedge clk);
        #1 check_val("tmo_early", 32'(err), 32'd0);
        @(posedge clk);
        #1 check_val("tmo_err", 32'(err), 32'd1);
        check_val("tmo_hold", 32'(cpu_hold), 32'd1);
        check_val("tmo_nwr", 32'(got_q.size()), 32'd0);
        build_frame(3, 0);
        run_frame("tmo_restart", 1);

        // Reset mid-frame during LO
        got_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h34;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g);
        end
        check_val("midrst_nwr", 32'(got_q.size()), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_err", 32'(err), 32'd0);
        check_val("midrst_hold", 32'(cpu_hold), 32'd1);
        build_frame(2, 0);
        run_frame("midrst_load", 0);

        // Randomized frames with gaps and interleaved garbage
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            build_frame($urandom_range(1, 6), $urandom_range(0, 2));
            run_frame("rand", 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
